// File: rtl/bsg_manycore_host_req_arbiter.sv
// Credit-managed round-robin arbiter feeding the host's single manycore endpoint
// request port from several host-side requesters, with reset-done gating and a drain fence.
module bsg_manycore_host_req_arbiter #(
  parameter int num_req_p         = 2,
  parameter int packet_width_p    = 128,
  parameter int max_out_credits_p = 16,
  parameter int credit_width_lp   = $clog2(max_out_credits_p + 1),
  localparam int id_width_lp      = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                reset_done_i,
  input  logic [num_req_p-1:0]                req_v_i,
  input  logic [num_req_p*packet_width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]                req_ready_o,
  output logic                                packet_v_o,
  output logic [packet_width_p-1:0]           packet_o,
  input  logic                                packet_ready_i,
  input  logic                                credit_return_i,
  input  logic                                fence_i,
  output logic [credit_width_lp-1:0]          out_credits_o,
  output logic [id_width_lp-1:0]              grant_id_o,
  output logic                                fence_busy_o,
  output logic                                error_o
);

  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);
  localparam logic [credit_width_lp-1:0] one_credit_lp  = credit_width_lp'(1);

  typedef enum logic [1:0] {
    WAIT_RESET = 2'd0,
    RUN        = 2'd1,
    FENCE      = 2'd2
  } state_e;

  state_e                         state_r, state_n;
  logic [id_width_lp-1:0]         rr_r, rr_n, grant_id_n;
  logic [2*num_req_p-1:0]         req_rot;
  logic                           found;
  int                             sel;
  logic                           grant;
  logic                           credit_at_max;
  logic [credit_width_lp-1:0]     credits_n;
  logic [packet_width_p-1:0]      grant_data;

  // Rotate so that bit 0 is the requester the rr pointer favours this cycle.
  assign req_rot = {req_v_i, req_v_i} >> rr_r;

  always_comb begin
    found = 1'b0;
    sel   = 0;
    for (int k = 0; k < num_req_p; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        sel   = int'(rr_r) + k;
      end
    end
    if (sel >= num_req_p) sel = sel - num_req_p;
  end

  assign grant_id_n = id_width_lp'(sel);
  assign rr_n       = (sel == num_req_p - 1) ? '0 : id_width_lp'(sel + 1);
  assign grant_data = packet_width_p'(req_data_i >> (sel * packet_width_p));

  assign grant = (state_r == RUN) && found && !fence_i
              && (out_credits_o != '0) && (!packet_v_o || packet_ready_i);

  assign req_ready_o  = grant ? (num_req_p'(1) << sel) : '0;
  assign fence_busy_o = (state_r == FENCE);

  // A return with every credit already home is dropped rather than wrapping the counter.
  assign credit_at_max = (out_credits_o == max_credits_lp);

  always_comb begin
    credits_n = out_credits_o;
    if (grant)                            credits_n = credits_n - one_credit_lp;
    if (credit_return_i && !credit_at_max) credits_n = credits_n + one_credit_lp;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      WAIT_RESET: if (reset_done_i) state_n = RUN;
      RUN:        if (fence_i) state_n = FENCE;
      FENCE:      if (credit_at_max && !packet_v_o) state_n = RUN;
      default:    state_n = WAIT_RESET;
    endcase
  end

  // Output register stage: loaded on grant, cleared when drained with nothing new behind it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r       <= WAIT_RESET;
      out_credits_o <= max_credits_lp;
      packet_v_o    <= 1'b0;
      packet_o      <= '0;
      grant_id_o    <= '0;
      rr_r          <= '0;
      error_o       <= 1'b0;
    end else begin
      state_r       <= state_n;
      out_credits_o <= credits_n;
      if (credit_return_i && credit_at_max) error_o <= 1'b1;
      if (grant) begin
        packet_v_o <= 1'b1;
        packet_o   <= grant_data;
        grant_id_o <= grant_id_n;
        rr_r       <= rr_n;
      end else if (packet_ready_i) begin
        packet_v_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bsg_manycore_host_req_arbiter.sv
// Directed bench for bsg_manycore_host_req_arbiter with 2 requesters, 128-bit packets, 16 credits.
module tb_bsg_manycore_host_req_arbiter;

  logic         clk_i = 1'b0;
  logic         reset_i, reset_done_i;
  logic [1:0]   req_v_i;
  logic [255:0] req_data_i;
  logic [1:0]   req_ready_o;
  logic         packet_v_o;
  logic [127:0] packet_o;
  logic         packet_ready_i, credit_return_i, fence_i;
  logic [4:0]   out_credits_o;
  logic [0:0]   grant_id_o;
  logic         fence_busy_o, error_o;

  logic [127:0] data0, data1;
  int n_checks = 0;
  int n_pass   = 0;

  bsg_manycore_host_req_arbiter #(
    .num_req_p(2), .packet_width_p(128), .max_out_credits_p(16)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .reset_done_i(reset_done_i),
    .req_v_i(req_v_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .packet_v_o(packet_v_o), .packet_o(packet_o), .packet_ready_i(packet_ready_i),
    .credit_return_i(credit_return_i), .fence_i(fence_i),
    .out_credits_o(out_credits_o), .grant_id_o(grant_id_o),
    .fence_busy_o(fence_busy_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset;
    reset_i = 1'b1; reset_done_i = 1'b1; req_v_i = 2'b00; fence_i = 1'b0;
    credit_return_i = 1'b0; packet_ready_i = 1'b1; req_data_i = {data1, data0};
    tick; tick;
    reset_i = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    reset_i = 1'b1; reset_done_i = 1'b0; req_v_i = 2'b11; fence_i = 1'b0;
    credit_return_i = 1'b0; packet_ready_i = 1'b1; req_data_i = {data1, data0};
    tick; tick;
    n_checks++; if (out_credits_o !== 5'd16) $display("FAIL rst_credits: got %0d expected 16", out_credits_o); else n_pass++;
    n_checks++; if (packet_v_o !== 1'b0) $display("FAIL rst_packet_v: got %0b expected 0", packet_v_o); else n_pass++;
    n_checks++; if (packet_o !== 128'd0) $display("FAIL rst_packet: got %0h expected 0", packet_o); else n_pass++;
    n_checks++; if (grant_id_o !== 1'b0) $display("FAIL rst_grant_id: got %0d expected 0", grant_id_o); else n_pass++;
    n_checks++; if (fence_busy_o !== 1'b0) $display("FAIL rst_fence_busy: got %0b expected 0", fence_busy_o); else n_pass++;
    n_checks++; if (error_o !== 1'b0) $display("FAIL rst_error: got %0b expected 0", error_o); else n_pass++;
    reset_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++; if (req_ready_o !== 2'b00) $display("FAIL gate_ready[%0d]: got %b expected 00", i, req_ready_o); else n_pass++;
      n_checks++; if (packet_v_o !== 1'b0) $display("FAIL gate_packet_v[%0d]: got %0b expected 0", i, packet_v_o); else n_pass++;
      tick;
    end
    n_checks++; if (out_credits_o !== 5'd16) $display("FAIL gate_credits: got %0d expected 16", out_credits_o); else n_pass++;
    reset_done_i = 1'b1;
    #1;
    n_checks++; if (req_ready_o !== 2'b00) $display("FAIL done_same_cycle: got %b expected 00", req_ready_o); else n_pass++;
    tick;
    n_checks++; if (req_ready_o !== 2'b01) $display("FAIL done_first_grant: got %b expected 01", req_ready_o); else n_pass++;
    tick;
    n_checks++; if (packet_v_o !== 1'b1) $display("FAIL done_packet_v: got %0b expected 1", packet_v_o); else n_pass++;
    n_checks++; if (packet_o !== data0) $display("FAIL done_packet: got %0h expected %0h", packet_o, data0); else n_pass++;
    n_checks++; if (grant_id_o !== 1'b0) $display("FAIL done_grant_id: got %0d expected 0", grant_id_o); else n_pass++;
  endtask

  task automatic test_round_robin;
    logic         exp_id;
    logic [127:0] exp_pkt;
    apply_reset;
    req_v_i = 2'b11;
    #1;
    n_checks++; if (req_ready_o !== 2'b01) $display("FAIL rr_first_ready: got %b expected 01", req_ready_o); else n_pass++;
    tick;
    n_checks++; if (out_credits_o !== 5'd15) $display("FAIL rr_first_credits: got %0d expected 15", out_credits_o); else n_pass++;
    credit_return_i = 1'b1;
    reset_done_i    = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      exp_id  = (i % 2 == 0) ? 1'b1 : 1'b0;
      exp_pkt = exp_id ? data1 : data0;
      n_checks++; if (grant_id_o !== exp_id) $display("FAIL rr_grant_id[%0d]: got %0d expected %0d", i, grant_id_o, exp_id); else n_pass++;
      n_checks++; if (packet_o !== exp_pkt) $display("FAIL rr_packet[%0d]: got %0h expected %0h", i, packet_o, exp_pkt); else n_pass++;
      n_checks++; if (out_credits_o !== 5'd15) $display("FAIL rr_credits[%0d]: got %0d expected 15", i, out_credits_o); else n_pass++;
    end
    credit_return_i = 1'b0;
    reset_done_i    = 1'b1;
  endtask

  task automatic test_credit_exhaustion;
    int grants;
    apply_reset;
    req_v_i = 2'b11;
    grants  = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready_o != 2'b00) grants++;
      tick;
    end
    #1;
    n_checks++; if (grants !== 16) $display("FAIL exh_grants: got %0d expected 16", grants); else n_pass++;
    n_checks++; if (out_credits_o !== 5'd0) $display("FAIL exh_credits: got %0d expected 0", out_credits_o); else n_pass++;
    n_checks++; if (packet_v_o !== 1'b0) $display("FAIL exh_packet_v: got %0b expected 0", packet_v_o); else n_pass++;
    credit_return_i = 1'b1;
    #1;
    n_checks++; if (req_ready_o !== 2'b00) $display("FAIL exh_ready_at_zero: got %b expected 00", req_ready_o); else n_pass++;
    tick;
    credit_return_i = 1'b0;
    #1;
    n_checks++; if (out_credits_o !== 5'd1) $display("FAIL exh_returned: got %0d expected 1", out_credits_o); else n_pass++;
    n_checks++; if (req_ready_o !== 2'b01) $display("FAIL exh_regrant: got %b expected 01", req_ready_o); else n_pass++;
    tick;
    n_checks++; if (out_credits_o !== 5'd0) $display("FAIL exh_after_regrant: got %0d expected 0", out_credits_o); else n_pass++;
    n_checks++; if (req_ready_o !== 2'b00) $display("FAIL exh_single_regrant: got %b expected 00", req_ready_o); else n_pass++;
  endtask

  task automatic test_backpressure;
    apply_reset;
    req_v_i = 2'b11;
    packet_ready_i = 1'b0;
    #1;
    n_checks++; if (req_ready_o !== 2'b01) $display("FAIL bp_empty_grant: got %b expected 01", req_ready_o); else n_pass++;
    tick;
    req_data_i = {~data1, ~data0};
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (req_ready_o !== 2'b00) $display("FAIL bp_ready[%0d]: got %b expected 00", i, req_ready_o); else n_pass++;
      n_checks++; if (packet_o !== data0) $display("FAIL bp_packet[%0d]: got %0h expected %0h", i, packet_o, data0); else n_pass++;
      n_checks++; if (grant_id_o !== 1'b0) $display("FAIL bp_grant_id[%0d]: got %0d expected 0", i, grant_id_o); else n_pass++;
      n_checks++; if (out_credits_o !== 5'd15) $display("FAIL bp_credits[%0d]: got %0d expected 15", i, out_credits_o); else n_pass++;
      tick;
    end
    packet_ready_i = 1'b1;
    #1;
    n_checks++; if (req_ready_o !== 2'b10) $display("FAIL bp_release_ready: got %b expected 10", req_ready_o); else n_pass++;
    tick;
    n_checks++; if (packet_o !== ~data1) $display("FAIL bp_next_packet: got %0h expected %0h", packet_o, ~data1); else n_pass++;
    n_checks++; if (out_credits_o !== 5'd14) $display("FAIL bp_next_credits: got %0d expected 14", out_credits_o); else n_pass++;
    req_data_i = {data1, data0};
  endtask

  task automatic test_fence;
    apply_reset;
    req_v_i = 2'b11;
    tick; tick; tick;
    fence_i = 1'b1;
    #1;
    n_checks++; if (req_ready_o !== 2'b00) $display("FAIL fence_pulse_ready: got %b expected 00", req_ready_o); else n_pass++;
    n_checks++; if (out_credits_o !== 5'd13) $display("FAIL fence_outstanding: got %0d expected 13", out_credits_o); else n_pass++;
    tick;
    fence_i = 1'b0;
    #1;
    n_checks++; if (fence_busy_o !== 1'b1) $display("FAIL fence_busy_set: got %0b expected 1", fence_busy_o); else n_pass++;
    n_checks++; if (packet_v_o !== 1'b0) $display("FAIL fence_drained: got %0b expected 0", packet_v_o); else n_pass++;
    for (int r = 0; r < 3; r++) begin
      credit_return_i = 1'b1;
      #1;
      n_checks++; if (fence_busy_o !== 1'b1) $display("FAIL fence_busy_hold[%0d]: got %0b expected 1", r, fence_busy_o); else n_pass++;
      n_checks++; if (req_ready_o !== 2'b00) $display("FAIL fence_no_grant[%0d]: got %b expected 00", r, req_ready_o); else n_pass++;
      tick;
    end
    credit_return_i = 1'b0;
    #1;
    n_checks++; if (out_credits_o !== 5'd16) $display("FAIL fence_all_home: got %0d expected 16", out_credits_o); else n_pass++;
    tick;
    n_checks++; if (fence_busy_o !== 1'b0) $display("FAIL fence_busy_clear: got %0b expected 0", fence_busy_o); else n_pass++;
    n_checks++; if (req_ready_o !== 2'b10) $display("FAIL fence_resume: got %b expected 10", req_ready_o); else n_pass++;
  endtask

  task automatic test_fence_idle;
    apply_reset;
    req_v_i = 2'b11;
    fence_i = 1'b1;
    #1;
    n_checks++; if (req_ready_o !== 2'b00) $display("FAIL fidle_t_ready: got %b expected 00", req_ready_o); else n_pass++;
    tick;
    fence_i = 1'b0;
    #1;
    n_checks++; if (fence_busy_o !== 1'b1) $display("FAIL fidle_t1_busy: got %0b expected 1", fence_busy_o); else n_pass++;
    n_checks++; if (req_ready_o !== 2'b00) $display("FAIL fidle_t1_ready: got %b expected 00", req_ready_o); else n_pass++;
    tick;
    n_checks++; if (fence_busy_o !== 1'b0) $display("FAIL fidle_t2_busy: got %0b expected 0", fence_busy_o); else n_pass++;
    n_checks++; if (req_ready_o !== 2'b01) $display("FAIL fidle_t2_ready: got %b expected 01", req_ready_o); else n_pass++;
  endtask

  task automatic test_error_reset;
    apply_reset;
    credit_return_i = 1'b1;
    #1;
    tick;
    credit_return_i = 1'b0;
    #1;
    n_checks++; if (out_credits_o !== 5'd16) $display("FAIL err_no_wrap: got %0d expected 16", out_credits_o); else n_pass++;
    n_checks++; if (error_o !== 1'b1) $display("FAIL err_set: got %0b expected 1", error_o); else n_pass++;
    req_v_i = 2'b01;
    packet_ready_i = 1'b0;
    tick;
    req_v_i = 2'b00;
    #1;
    n_checks++; if (packet_v_o !== 1'b1) $display("FAIL err_pending: got %0b expected 1", packet_v_o); else n_pass++;
    n_checks++; if (error_o !== 1'b1) $display("FAIL err_sticky: got %0b expected 1", error_o); else n_pass++;
    reset_i = 1'b1;
    reset_done_i = 1'b0;
    tick;
    n_checks++; if (error_o !== 1'b0) $display("FAIL err_reset_error: got %0b expected 0", error_o); else n_pass++;
    n_checks++; if (packet_v_o !== 1'b0) $display("FAIL err_reset_packet_v: got %0b expected 0", packet_v_o); else n_pass++;
    n_checks++; if (out_credits_o !== 5'd16) $display("FAIL err_reset_credits: got %0d expected 16", out_credits_o); else n_pass++;
    n_checks++; if (packet_o !== 128'd0) $display("FAIL err_reset_packet: got %0h expected 0", packet_o); else n_pass++;
    reset_i = 1'b0;
    req_v_i = 2'b11;
    packet_ready_i = 1'b1;
    tick;
    n_checks++; if (req_ready_o !== 2'b00) $display("FAIL err_wait_reset_ready: got %b expected 00", req_ready_o); else n_pass++;
    n_checks++; if (packet_v_o !== 1'b0) $display("FAIL err_wait_reset_packet_v: got %0b expected 0", packet_v_o); else n_pass++;
  endtask

  initial begin
    data0 = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    data1 = 128'hfedc_ba98_7654_3210_8899_aabb_ccdd_eeff;
    test_reset;
    test_round_robin;
    test_credit_exhaustion;
    test_backpressure;
    test_fence;
    test_fence_idle;
    test_error_reset;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
